control_sequencer: RTL

//  Hardwired control unit that drives the DataPath strobes. Runs fetch T0-T2, then a per-opcode execute sequence T3-T7.

---
 rtl/control_sequencer_pkg.sv | 50 +++++
 rtl/control_sequencer_if.sv | 35 +++
 rtl/control_sequencer_opcode_decode.sv | 43 ++++
 rtl/control_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared types for the hardwired control unit and the DataPath.
//   Holds the FSM step encoding, instruction opcodes, ALU operation codes,
//   instruction classes and the packed strobe bundle driven each cycle.
package control_sequencer_pkg;

   localparam int unsigned INSTR_W    = 32;
   localparam int unsigned OPCODE_W   = 5;
   localparam int unsigned OPCODE_LSB = INSTR_W - OPCODE_W;
   localparam int unsigned ALU_OP_W   = 5;

   // Sequencer steps; HALT is left only through clear
   typedef enum logic [3:0] {
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_e;

   // IR[31:27] opcode values; anything not listed is illegal
   typedef enum logic [OPCODE_W-1:0] {
      OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
      OP_BR   = 5'b00100, OP_SUB  = 5'b00101, OP_AND  = 5'b00110, OP_OR   = 5'b00111,
      OP_SHR  = 5'b01000, OP_SHL  = 5'b01001, OP_ADDI = 5'b01010, OP_ANDI = 5'b01011,
      OP_ORI  = 5'b01100, OP_MUL  = 5'b01101, OP_DIV  = 5'b01110, OP_NEG  = 5'b01111,
      OP_NOT  = 5'b10000, OP_JR   = 5'b10001, OP_MFHI = 5'b10011, OP_MFLO = 5'b10100,
      OP_NOP  = 5'b10101, OP_HALT = 5'b10110
   } opcode_e;

   // ALU select; ALU_NONE is driven whenever no ALU step is active
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_NONE = 5'd0,  ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3,
      ALU_OR   = 5'd4,  ALU_SHR = 5'd5, ALU_SHL = 5'd6, ALU_MUL = 5'd7,
      ALU_DIV  = 5'd8,  ALU_NEG = 5'd9, ALU_NOT = 5'd10
   } alu_op_e;

   // Execute-sequence families sharing one T3..T7 pattern
   typedef enum logic [3:0] {
      CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I, CLS_BR, CLS_MULDIV,
      CLS_UNARY, CLS_JR, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } instr_class_e;

   // All single-bit DataPath strobes of one step
   typedef struct packed {
      logic pc_out;   logic mar_in;    logic inc_pc;    logic z_in;
      logic pc_in;    logic mdr_in;    logic ir_in;     logic mdr_out;
      logic gra;      logic grb;       logic grc;       logic ba_out;
      logic r_in;     logic r_out;     logic y_in;      logic y_out;
      logic c_out;    logic zlow_out;  logic zhigh_out; logic hi_in;
      logic hi_out;   logic lo_in;     logic lo_out;    logic con_in;
      logic ram_read; logic ram_write; logic change_pc;
   } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: sequencer <-> DataPath/RAM bundle.
//   Inputs to the sequencer: instruction (IR), CON, mem_ready.
//   Outputs from the sequencer: DataPath strobes, ram_read/ram_write/change_PC,
//   alu_op, run, illegal_op, mem_error.
//   master = control sequencer, slave = DataPath side.
interface control_sequencer_if;
   import control_sequencer_pkg::*;

   logic [INSTR_W-1:0]  instruction;
   logic                CON;
   logic                mem_ready;

   logic PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout;
   logic Gra, Grb, Grc, BAout, Rin, Rout, Yin, Yout, Cout;
   logic Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin;
   logic ram_read, ram_write, change_PC;
   logic [ALU_OP_W-1:0] alu_op;
   logic run, illegal_op, mem_error;

   modport master (
      input  instruction, CON, mem_ready,
      output PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout,
             Gra, Grb, Grc, BAout, Rin, Rout, Yin, Yout, Cout,
             Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin,
             ram_read, ram_write, change_PC, alu_op, run, illegal_op, mem_error
   );

   modport slave (
      output instruction, CON, mem_ready,
      input  PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout,
             Gra, Grb, Grc, BAout, Rin, Rout, Yin, Yout, Cout,
             Zlowout, Zhighout, HIin, HIout, LOin, LOout, CONin,
             ram_read, ram_write, change_PC, alu_op, run, illegal_op, mem_error
   );
endinterface

// File: rtl/control_sequencer_opcode_decode.sv
// control_sequencer_opcode_decode: combinational opcode decode.
//   opcode        in   5  IR[31:27]
//   instr_class_c out     execute-sequence family
//   alu_op_c      out  5  ALU operation used by that instruction's ALU step
module control_sequencer_opcode_decode
   import control_sequencer_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output instr_class_e        instr_class_c,
   output alu_op_e             alu_op_c
);

   always_comb begin
      instr_class_c = CLS_ILLEGAL;
      alu_op_c      = ALU_NONE;
      case (opcode)
         OP_LD:   begin instr_class_c = CLS_LD;     alu_op_c = ALU_ADD; end
         OP_LDI:  begin instr_class_c = CLS_LDI;    alu_op_c = ALU_ADD; end
         OP_ST:   begin instr_class_c = CLS_ST;     alu_op_c = ALU_ADD; end
         OP_ADD:  begin instr_class_c = CLS_ALU_R;  alu_op_c = ALU_ADD; end
         OP_SUB:  begin instr_class_c = CLS_ALU_R;  alu_op_c = ALU_SUB; end
         OP_AND:  begin instr_class_c = CLS_ALU_R;  alu_op_c = ALU_AND; end
         OP_OR:   begin instr_class_c = CLS_ALU_R;  alu_op_c = ALU_OR;  end
         OP_SHR:  begin instr_class_c = CLS_ALU_R;  alu_op_c = ALU_SHR; end
         OP_SHL:  begin instr_class_c = CLS_ALU_R;  alu_op_c = ALU_SHL; end
         OP_ADDI: begin instr_class_c = CLS_ALU_I;  alu_op_c = ALU_ADD; end
         OP_ANDI: begin instr_class_c = CLS_ALU_I;  alu_op_c = ALU_AND; end
         OP_ORI:  begin instr_class_c = CLS_ALU_I;  alu_op_c = ALU_OR;  end
         OP_BR:   begin instr_class_c = CLS_BR;     alu_op_c = ALU_ADD; end
         OP_MUL:  begin instr_class_c = CLS_MULDIV; alu_op_c = ALU_MUL; end
         OP_DIV:  begin instr_class_c = CLS_MULDIV; alu_op_c = ALU_DIV; end
         OP_NEG:  begin instr_class_c = CLS_UNARY;  alu_op_c = ALU_NEG; end
         OP_NOT:  begin instr_class_c = CLS_UNARY;  alu_op_c = ALU_NOT; end
         OP_JR:   instr_class_c = CLS_JR;
         OP_MFHI: instr_class_c = CLS_MFHI;
         OP_MFLO: instr_class_c = CLS_MFLO;
         OP_NOP:  instr_class_c = CLS_NOP;
         OP_HALT: instr_class_c = CLS_HALT;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit running fetch (T0-T2) and a
//   per-opcode execute sequence (T3-T7) so the DataPath runs programs from RAM.
//   clock   in  system clock, rising edge
//   clear   in  synchronous active-high reset (returns to T0, clears mem_error)
//   bus     master side of control_sequencer_if (IR/CON/mem_ready in; strobes,
//           alu_op, run, illegal_op, mem_error out)
//   TIMEOUT_CYCLES  mem_ready wait limit, effective only with CTRL_MEM_TIMEOUT_EN.
//   Build option CTRL_MEM_TIMEOUT_EN: memory steps time out into HALT and set
//   sticky mem_error; without it memory steps wait forever and mem_error is 0.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
)
(
   input  logic                 clock,
   input  logic                 clear,
   control_sequencer_if.master  bus
);

   state_e       state_q, state_d;
   instr_class_e instr_class_c;
   alu_op_e      dec_alu_op_c;
   alu_op_e      alu_c;
   strobes_t     stb_c;
   logic         illegal_c, run_c, mem_step_c, timeout_c, mem_error_c;
   logic         unused_ir;

   assign unused_ir = ^bus.instruction[OPCODE_LSB-1:0];

   control_sequencer_opcode_decode u_decode (
      .opcode        (bus.instruction[INSTR_W-1 -: OPCODE_W]),
      .instr_class_c (instr_class_c),
      .alu_op_c      (dec_alu_op_c)
   );

   // Steps that wait on mem_ready
   assign mem_step_c = (state_q == ST_T1)
                    || (state_q == ST_T6 && instr_class_c == CLS_LD)
                    || (state_q == ST_T7 && instr_class_c == CLS_ST);

`ifdef CTRL_MEM_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             mem_error_q;

   // Cycles spent in the current memory step without mem_ready
   always_ff @(posedge clock) begin
      if (clear)
         tmo_cnt_q <= '0;
      else if (mem_step_c && !bus.mem_ready && !timeout_c)
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      else
         tmo_cnt_q <= '0;
   end

   assign timeout_c = mem_step_c && !bus.mem_ready
                   && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Sticky until clear
   always_ff @(posedge clock) begin
      if (clear)
         mem_error_q <= 1'b0;
      else if (timeout_c)
         mem_error_q <= 1'b1;
   end

   assign mem_error_c = mem_error_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign timeout_c      = 1'b0;
   assign mem_error_c    = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (clear)
         state_q <= ST_T0;
      else
         state_q <= state_d;
   end

   // Next state and strobe decode of (state, class, CON)
   always_comb begin
      state_d   = state_q;
      stb_c     = '0;
      alu_c     = ALU_NONE;
      illegal_c = 1'b0;
      run_c     = 1'b1;
      case (state_q)
         ST_T0: begin
            stb_c.pc_out = 1'b1; stb_c.mar_in = 1'b1; stb_c.inc_pc = 1'b1; stb_c.z_in = 1'b1;
            state_d = ST_T1;
         end
         ST_T1: begin
            stb_c.zlow_out = 1'b1; stb_c.pc_in = 1'b1; stb_c.ram_read = 1'b1; stb_c.mdr_in = 1'b1;
            if (timeout_c)          state_d = ST_HALT;
            else if (bus.mem_ready) state_d = ST_T2;
         end
         ST_T2: begin
            stb_c.mdr_out = 1'b1; stb_c.ir_in = 1'b1;
            state_d = ST_T3;
         end
         ST_T3: begin
            state_d = ST_T4;
            case (instr_class_c)
               CLS_ALU_R, CLS_ALU_I: begin stb_c.grb = 1'b1; stb_c.r_out = 1'b1; stb_c.y_in = 1'b1; end
               CLS_LDI, CLS_LD, CLS_ST: begin stb_c.grb = 1'b1; stb_c.ba_out = 1'b1; stb_c.y_in = 1'b1; end
               CLS_BR:     begin stb_c.gra = 1'b1; stb_c.r_out = 1'b1; stb_c.con_in = 1'b1; end
               CLS_MULDIV: begin stb_c.gra = 1'b1; stb_c.r_out = 1'b1; stb_c.y_in = 1'b1; end
               CLS_UNARY: begin
                  stb_c.grb = 1'b1; stb_c.r_out = 1'b1; stb_c.z_in = 1'b1; alu_c = dec_alu_op_c;
               end
               CLS_JR: begin
                  stb_c.gra = 1'b1; stb_c.r_out = 1'b1; stb_c.pc_in = 1'b1; state_d = ST_T0;
               end
               CLS_MFHI: begin
                  stb_c.hi_out = 1'b1; stb_c.gra = 1'b1; stb_c.r_in = 1'b1; state_d = ST_T0;
               end
               CLS_MFLO: begin
                  stb_c.lo_out = 1'b1; stb_c.gra = 1'b1; stb_c.r_in = 1'b1; state_d = ST_T0;
               end
               CLS_HALT: state_d = ST_HALT;
               CLS_NOP:  state_d = ST_T0;
               default: begin illegal_c = 1'b1; state_d = ST_T0; end
            endcase
         end
         ST_T4: begin
            state_d = ST_T5;
            case (instr_class_c)
               CLS_ALU_R: begin
                  stb_c.grc = 1'b1; stb_c.r_out = 1'b1; stb_c.z_in = 1'b1; alu_c = dec_alu_op_c;
               end
               CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST: begin
                  stb_c.c_out = 1'b1; stb_c.z_in = 1'b1; alu_c = dec_alu_op_c;
               end
               CLS_BR: begin stb_c.pc_out = 1'b1; stb_c.y_in = 1'b1; end
               CLS_MULDIV: begin
                  stb_c.grb = 1'b1; stb_c.r_out = 1'b1; stb_c.z_in = 1'b1; alu_c = dec_alu_op_c;
               end
               CLS_UNARY: begin
                  stb_c.zlow_out = 1'b1; stb_c.gra = 1'b1; stb_c.r_in = 1'b1; state_d = ST_T0;
               end
               default: state_d = ST_T0;
            endcase
         end
         ST_T5: begin
            state_d = ST_T6;
            case (instr_class_c)
               CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                  stb_c.zlow_out = 1'b1; stb_c.gra = 1'b1; stb_c.r_in = 1'b1; state_d = ST_T0;
               end
               CLS_LD, CLS_ST: begin stb_c.zlow_out = 1'b1; stb_c.mar_in = 1'b1; end
               CLS_BR: begin stb_c.c_out = 1'b1; stb_c.z_in = 1'b1; alu_c = dec_alu_op_c; end
               CLS_MULDIV: begin stb_c.zlow_out = 1'b1; stb_c.lo_in = 1'b1; end
               default: state_d = ST_T0;
            endcase
         end
         ST_T6: begin
            state_d = ST_T0;
            case (instr_class_c)
               CLS_LD: begin
                  stb_c.ram_read = 1'b1; stb_c.mdr_in = 1'b1;
                  if (timeout_c)          state_d = ST_HALT;
                  else if (bus.mem_ready) state_d = ST_T7;
                  else                    state_d = ST_T6;
               end
               CLS_ST: begin
                  stb_c.gra = 1'b1; stb_c.r_out = 1'b1; stb_c.mdr_in = 1'b1; state_d = ST_T7;
               end
               CLS_BR: begin
                  // Branch taken only when the condition flop is set
                  stb_c.zlow_out  = 1'b1;
                  stb_c.pc_in     = bus.CON;
                  stb_c.change_pc = bus.CON;
               end
               CLS_MULDIV: begin stb_c.zhigh_out = 1'b1; stb_c.hi_in = 1'b1; end
               default: ;
            endcase
         end
         ST_T7: begin
            state_d = ST_T0;
            case (instr_class_c)
               CLS_LD: begin stb_c.mdr_out = 1'b1; stb_c.gra = 1'b1; stb_c.r_in = 1'b1; end
               CLS_ST: begin
                  stb_c.ram_write = 1'b1;
                  if (timeout_c)           state_d = ST_HALT;
                  else if (!bus.mem_ready) state_d = ST_T7;
               end
               default: ;
            endcase
         end
         ST_HALT: run_c = 1'b0;
         default: state_d = ST_T0;
      endcase

      // Everything reads 0 while clear is held
      if (clear) begin
         stb_c     = '0;
         alu_c     = ALU_NONE;
         illegal_c = 1'b0;
         run_c     = 1'b0;
      end
   end

   assign bus.PCout      = stb_c.pc_out;
   assign bus.MARin      = stb_c.mar_in;
   assign bus.IncPC      = stb_c.inc_pc;
   assign bus.Zin        = stb_c.z_in;
   assign bus.PCin       = stb_c.pc_in;
   assign bus.MDRin      = stb_c.mdr_in;
   assign bus.IRin       = stb_c.ir_in;
   assign bus.MDRout     = stb_c.mdr_out;
   assign bus.Gra        = stb_c.gra;
   assign bus.Grb        = stb_c.grb;
   assign bus.Grc        = stb_c.grc;
   assign bus.BAout      = stb_c.ba_out;
   assign bus.Rin        = stb_c.r_in;
   assign bus.Rout       = stb_c.r_out;
   assign bus.Yin        = stb_c.y_in;
   assign bus.Yout       = stb_c.y_out;
   assign bus.Cout       = stb_c.c_out;
   assign bus.Zlowout    = stb_c.zlow_out;
   assign bus.Zhighout   = stb_c.zhigh_out;
   assign bus.HIin       = stb_c.hi_in;
   assign bus.HIout      = stb_c.hi_out;
   assign bus.LOin       = stb_c.lo_in;
   assign bus.LOout      = stb_c.lo_out;
   assign bus.CONin      = stb_c.con_in;
   assign bus.ram_read   = stb_c.ram_read;
   assign bus.ram_write  = stb_c.ram_write;
   assign bus.change_PC  = stb_c.change_pc;
   assign bus.alu_op     = alu_c;
   assign bus.run        = run_c;
   assign bus.illegal_op = illegal_c;
   assign bus.mem_error  = mem_error_c & ~clear;

endmodule
